// File: rtl/rx_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_dma_pkg
//  Description : Shared constants for the RX DMA burst writer: FSM state
//                encodings and the AXI burst/response codes it uses.
//  Revision    : 1.0 - initial release
// ============================================================================
package rx_dma_pkg;

    // FSM state encoding (2-bit, legacy-compatible constants)
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage
`default_nettype wire

// File: rtl/axi_burst_len_calc.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_len_calc
//  Description : Combinational burst sizing. Returns the number of beats for
//                the next burst: the smallest of the beats still owed, the
//                configured burst cap, and the beats left before the next
//                4 KiB boundary.
//  Ports       : i_beats_left - beats remaining in the whole transfer
//                i_addr_lo    - low 12 bits of the (beat-aligned) address
//                o_n          - beats in the next burst (1..256)
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_len_calc
    import rx_dma_pkg::*;
#(
    parameter int MAX_BURST_BEATS = 16,
    parameter int BYTES           = 16,
    parameter int BL_W            = 13
) (
    input  logic [BL_W-1:0] i_beats_left,
    input  logic [11:0]     i_addr_lo,
    output logic [8:0]      o_n
);

    localparam int LOG2_BYTES = $clog2(BYTES);
    localparam int MW         = (BL_W > 13) ? BL_W : 13;

    logic [12:0]   w_page_room_bytes;
    logic [MW-1:0] w_page_beats;
    logic [MW-1:0] w_beats;
    logic [MW-1:0] w_cap;
    logic [MW-1:0] w_min;

    // Address is beat-aligned, so the byte room divides exactly into beats.
    assign w_page_room_bytes = 13'd4096 - {1'b0, i_addr_lo};
    assign w_page_beats      = MW'(w_page_room_bytes >> LOG2_BYTES);
    assign w_beats           = MW'(i_beats_left);
    assign w_cap             = MW'(MAX_BURST_BEATS);

    always_comb begin
        w_min = w_beats;
        if (w_cap < w_min) begin
            w_min = w_cap;
        end
        if (w_page_beats < w_min) begin
            w_min = w_page_beats;
        end
    end

    // Result is bounded by MAX_BURST_BEATS (<= 256), so 9 bits suffice.
    assign o_n = 9'(w_min);

endmodule
`default_nettype wire

// File: rtl/rx_dma_burst_writer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_dma_burst_writer
//  Description : Drains the RX data FIFO (FWFT) into memory with AXI4 INCR
//                write bursts. Bursts never cross 4 KiB; the final beat of a
//                transfer whose length is not a whole number of words is
//                masked with WSTRB. One burst outstanding at a time.
//  Ports       : clock/reset_n         - clock, sync active-low reset
//                i_start/i_addr/i_len  - transfer command, o_busy status
//                o_rd_en/i_rd_data/i_empty - FIFO read side
//                o_aw*/i_awready       - AXI write address channel
//                o_w*/i_wready         - AXI write data channel
//                i_bresp/i_bvalid/o_bready - AXI write response channel
//                o_err                 - sticky error on non-OKAY BRESP
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_dma_burst_writer
    import rx_dma_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH      = 128,
    parameter int MAX_BURST_BEATS = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    // memory-write command
    input  logic                      i_start,
    input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
    input  logic [15:0]               i_len,
    output logic                      o_busy,
    // FIFO read (first-word fall-through)
    output logic                      o_rd_en,
    input  logic [DATA_WIDTH-1:0]     i_rd_data,
    input  logic                      i_empty,
    // AXI write address
    output logic [AXI_ADDR_WIDTH-1:0] o_awaddr,
    output logic [7:0]                o_awlen,
    output logic [2:0]                o_awsize,
    output logic [1:0]                o_awburst,
    output logic                      o_awvalid,
    input  logic                      i_awready,
    // AXI write data
    output logic [DATA_WIDTH-1:0]     o_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_wstrb,
    output logic                      o_wlast,
    output logic                      o_wvalid,
    input  logic                      i_wready,
    // AXI write response
    input  logic [1:0]                i_bresp,
    input  logic                      i_bvalid,
    output logic                      o_bready,
    // status
    output logic                      o_err
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int LOG2_BYTES = $clog2(BYTES);
    // Enough bits for ceil(65535 / BYTES) beats.
    localparam int BL_W       = 17 - LOG2_BYTES;

    logic [1:0]                r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [BL_W-1:0]           r_beats_left;
    logic [LOG2_BYTES-1:0]     r_tail;
    logic [8:0]                r_burst_n;
    logic [8:0]                r_beat_cnt;
    logic                      r_err;

    logic [8:0]                w_burst_n;
    logic [16:0]               w_len_round;
    logic [BL_W-1:0]           w_len_beats;
    logic                      w_wvalid;
    logic                      w_wlast;
    logic                      w_final_beat;
    logic [BYTES-1:0]          w_tail_mask;

    assign w_len_round = {1'b0, i_len} + 17'(BYTES - 1);
    assign w_len_beats = BL_W'(w_len_round >> LOG2_BYTES);

    axi_burst_len_calc #(
        .MAX_BURST_BEATS (MAX_BURST_BEATS),
        .BYTES           (BYTES),
        .BL_W            (BL_W)
    ) u_len_calc (
        .i_beats_left (r_beats_left),
        .i_addr_lo    (r_addr[11:0]),
        .o_n          (w_burst_n)
    );

    assign w_wvalid = (r_state == S_W) && !i_empty;
    assign w_wlast  = (r_state == S_W) && (r_beat_cnt == r_burst_n - 9'd1);

    // beats_left is already decremented for the burst in flight, so zero
    // here means this burst carries the final beat of the transfer.
    assign w_final_beat = w_wlast && (r_beats_left == '0) && (r_tail != '0);
    assign w_tail_mask  = ~({BYTES{1'b1}} << r_tail);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_tail       <= '0;
            r_burst_n    <= '0;
            r_beat_cnt   <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_err        <= 1'b0;
                        r_addr       <= i_addr & ~AXI_ADDR_WIDTH'(BYTES - 1);
                        r_beats_left <= w_len_beats;
                        r_tail       <= i_len[LOG2_BYTES-1:0];
                        if (i_len != 16'd0) begin
                            r_state <= S_AW;
                        end
                    end
                end
                S_AW: begin
                    if (i_awready) begin
                        r_addr       <= r_addr + (AXI_ADDR_WIDTH'(w_burst_n) << LOG2_BYTES);
                        r_beats_left <= r_beats_left - BL_W'(w_burst_n);
                        r_burst_n    <= w_burst_n;
                        r_beat_cnt   <= '0;
                        r_state      <= S_W;
                    end
                end
                S_W: begin
                    if (w_wvalid && i_wready) begin
                        if (w_wlast) begin
                            r_state <= S_B;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 9'd1;
                        end
                    end
                end
                S_B: begin
                    if (i_bvalid) begin
                        if (i_bresp != AXI_RESP_OKAY) begin
                            r_err <= 1'b1;
                        end
                        r_state <= (r_beats_left != '0) ? S_AW : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_err     = r_err;

    assign o_awaddr  = r_addr;
    assign o_awlen   = 8'(w_burst_n - 9'd1);
    assign o_awsize  = 3'(LOG2_BYTES);
    assign o_awburst = AXI_BURST_INCR;
    assign o_awvalid = (r_state == S_AW);

    assign o_wdata   = i_rd_data;
    assign o_wstrb   = w_final_beat ? w_tail_mask : {BYTES{1'b1}};
    assign o_wlast   = w_wlast;
    assign o_wvalid  = w_wvalid;
    assign o_rd_en   = w_wvalid && i_wready;

    assign o_bready  = (r_state == S_B);

endmodule
`default_nettype wire

// File: tb/tb_rx_dma_burst_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_dma_burst_writer
//  Description : Directed self-checking bench for rx_dma_burst_writer with a
//                FWFT FIFO model and a simple AXI write slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_dma_burst_writer;

    localparam int DW = 128;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_start, i_empty, i_awready, i_wready, i_bvalid;
    logic [31:0]   i_addr;
    logic [15:0]   i_len;
    logic [DW-1:0] i_rd_data;
    logic [1:0]    i_bresp;
    logic          o_busy, o_rd_en, o_awvalid, o_wlast, o_wvalid, o_bready, o_err;
    logic [31:0]   o_awaddr;
    logic [7:0]    o_awlen;
    logic [2:0]    o_awsize;
    logic [1:0]    o_awburst;
    logic [DW-1:0] o_wdata;
    logic [15:0]   o_wstrb;

    logic [DW-1:0] fifo_q[$];
    logic [31:0]   aw_addr_q[$];
    logic [7:0]    aw_len_q[$];
    logic [DW-1:0] w_data_q[$];
    logic [15:0]   w_strb_q[$];
    logic          w_last_q[$];
    int            b_count = 0;
    int            rd_cnt = 0;
    int            viol = 0;
    int            slverr_idx = -1;
    bit            stall_en = 1'b0;
    bit            force_empty = 1'b0;
    bit            pend_b = 1'b0;
    int            tests_run = 0;
    int            tests_failed = 0;

    rx_dma_burst_writer #(
        .AXI_ADDR_WIDTH (32),
        .DATA_WIDTH     (DW),
        .MAX_BURST_BEATS(16)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_start  (i_start),
        .i_addr   (i_addr),
        .i_len    (i_len),
        .o_busy   (o_busy),
        .o_rd_en  (o_rd_en),
        .i_rd_data(i_rd_data),
        .i_empty  (i_empty),
        .o_awaddr (o_awaddr),
        .o_awlen  (o_awlen),
        .o_awsize (o_awsize),
        .o_awburst(o_awburst),
        .o_awvalid(o_awvalid),
        .i_awready(i_awready),
        .o_wdata  (o_wdata),
        .o_wstrb  (o_wstrb),
        .o_wlast  (o_wlast),
        .o_wvalid (o_wvalid),
        .i_wready (i_wready),
        .i_bresp  (i_bresp),
        .i_bvalid (i_bvalid),
        .o_bready (o_bready),
        .o_err    (o_err)
    );

    always #5 clock = ~clock;

    // FIFO + AXI slave model: drive at the falling edge, then log the
    // handshakes that the next rising edge will complete.
    always @(negedge clock) begin
        if (!reset_n) pend_b = 1'b0;
        i_bvalid  = pend_b;
        i_bresp   = (b_count == slverr_idx) ? 2'b10 : 2'b00;
        i_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        i_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        i_empty   = force_empty || (fifo_q.size() == 0);
        i_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        if (o_awvalid && i_awready) begin
            aw_addr_q.push_back(o_awaddr);
            aw_len_q.push_back(o_awlen);
        end
        if (o_wvalid && i_wready) begin
            w_data_q.push_back(o_wdata);
            w_strb_q.push_back(o_wstrb);
            w_last_q.push_back(o_wlast);
            if (o_wlast) pend_b = 1'b1;
        end
        if (o_wvalid && i_empty) viol++;
        if (o_rd_en) begin
            rd_cnt++;
            if (!(o_wvalid && i_wready)) viol++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        if (i_bvalid && o_bready) begin
            b_count++;
            pend_b = 1'b0;
        end
    end

    function automatic logic [DW-1:0] mkword(input int i);
        return {4{32'(i) ^ 32'hC0DE_0000}};
    endfunction

    task automatic clear_logs();
        aw_addr_q.delete(); aw_len_q.delete();
        w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
    endtask

    task automatic load_fifo(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(mkword(i));
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [15:0] l);
        @(negedge clock);
        i_start = 1'b1; i_addr = a; i_len = l;
        @(negedge clock);
        i_start = 1'b0;
        #2;
    endtask

    task automatic wait_b(input int target, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (b_count >= target) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clock); #2;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        #2;
        tests_run++;
        if ({o_busy, o_err, o_awvalid, o_wvalid, o_wlast, o_bready, o_rd_en} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {o_busy, o_err, o_awvalid, o_wvalid, o_wlast, o_bready, o_rd_en});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        bit to; int b0; int r0;
        clear_logs(); load_fifo(4);
        b0 = b_count; r0 = rd_cnt;
        start_xfer(32'h1000, 16'd64);
        tests_run++;
        if ({o_busy, o_awvalid} !== 2'b11) begin
            tests_failed++; $display("FAIL single_start: busy,awvalid got %b expected 11", {o_busy, o_awvalid});
        end
        tests_run++;
        if (o_awsize !== 3'd4 || o_awburst !== 2'b01) begin
            tests_failed++; $display("FAIL single_size_burst: got %0d/%0d expected 4/1", o_awsize, o_awburst);
        end
        wait_b(b0 + 1, to);
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL single_timeout: got timeout expected B response"); end
        tests_run++;
        if (o_busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_at_b: got %b expected 1", o_busy); end
        @(negedge clock); #2;
        tests_run++;
        if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_drop: got %b expected 0", o_busy); end
        tests_run++;
        if (aw_addr_q.size() !== 1 || w_data_q.size() !== 4) begin
            tests_failed++; $display("FAIL single_counts: aw %0d w %0d expected 1 4", aw_addr_q.size(), w_data_q.size());
        end
        if (aw_addr_q.size() > 0) begin
            tests_run++;
            if (aw_addr_q[0] !== 32'h1000 || aw_len_q[0] !== 8'd3) begin
                tests_failed++; $display("FAIL single_aw: got %h/%0d expected 1000/3", aw_addr_q[0], aw_len_q[0]);
            end
        end
        for (int i = 0; i < w_data_q.size(); i++) begin
            tests_run++;
            if (w_data_q[i] !== mkword(i) || w_strb_q[i] !== 16'hFFFF || w_last_q[i] !== (i == 3)) begin
                tests_failed++;
                $display("FAIL single_beat%0d: got %h/%h/%b expected %h/ffff/%b", i, w_data_q[i], w_strb_q[i],
                         w_last_q[i], mkword(i), (i == 3));
            end
        end
        tests_run++;
        if (rd_cnt - r0 !== 4) begin tests_failed++; $display("FAIL single_rd_en: got %0d expected 4", rd_cnt - r0); end
    endtask

    task automatic test_tail();
        bit to; int b0; int r0;
        clear_logs(); load_fifo(4);
        b0 = b_count; r0 = rd_cnt;
        start_xfer(32'h2000, 16'd60);
        wait_b(b0 + 1, to);
        @(negedge clock); #2;
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL tail_timeout: got timeout expected B response"); end
        if (aw_len_q.size() > 0) begin
            tests_run++;
            if (aw_addr_q[0] !== 32'h2000 || aw_len_q[0] !== 8'd3) begin
                tests_failed++; $display("FAIL tail_aw: got %h/%0d expected 2000/3", aw_addr_q[0], aw_len_q[0]);
            end
        end
        for (int i = 0; i < w_strb_q.size(); i++) begin
            tests_run++;
            if (w_strb_q[i] !== ((i == 3) ? 16'h0FFF : 16'hFFFF)) begin
                tests_failed++; $display("FAIL tail_strb%0d: got %h expected %h", i, w_strb_q[i],
                                         (i == 3) ? 16'h0FFF : 16'hFFFF);
            end
        end
        tests_run++;
        if (rd_cnt - r0 !== 4 || w_strb_q.size() !== 4) begin
            tests_failed++; $display("FAIL tail_rd_en: got %0d/%0d expected 4/4", rd_cnt - r0, w_strb_q.size());
        end
    endtask

    task automatic test_multi();
        bit to; int b0; int r0;
        clear_logs(); load_fifo(19);
        b0 = b_count; r0 = rd_cnt;
        start_xfer(32'h0, 16'd300);
        wait_b(b0 + 2, to);
        @(negedge clock); #2;
        tests_run++;
        if (to !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++; $display("FAIL multi_done: timeout %b busy %b expected 0 0", to, o_busy);
        end
        tests_run++;
        if (aw_addr_q.size() !== 2) begin tests_failed++; $display("FAIL multi_aw_count: got %0d expected 2", aw_addr_q.size()); end
        if (aw_addr_q.size() == 2) begin
            tests_run++;
            if (aw_addr_q[0] !== 32'h0 || aw_len_q[0] !== 8'd15 || aw_addr_q[1] !== 32'h100 || aw_len_q[1] !== 8'd2) begin
                tests_failed++; $display("FAIL multi_aw: got %h/%0d %h/%0d expected 0/15 100/2",
                                         aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
            end
        end
        for (int i = 0; i < w_data_q.size(); i++) begin
            tests_run++;
            if (w_data_q[i] !== mkword(i) || w_last_q[i] !== (i == 15 || i == 18) ||
                w_strb_q[i] !== ((i == 18) ? 16'h0FFF : 16'hFFFF)) begin
                tests_failed++; $display("FAIL multi_beat%0d: got %h/%h/%b", i, w_data_q[i], w_strb_q[i], w_last_q[i]);
            end
        end
        tests_run++;
        if (rd_cnt - r0 !== 19) begin tests_failed++; $display("FAIL multi_rd_en: got %0d expected 19", rd_cnt - r0); end
    endtask

    task automatic test_4k();
        bit to; int b0;
        clear_logs(); load_fifo(16);
        b0 = b_count;
        start_xfer(32'h0FC0, 16'd256);
        wait_b(b0 + 2, to);
        @(negedge clock); #2;
        tests_run++;
        if (to !== 1'b0 || aw_addr_q.size() !== 2 || w_data_q.size() !== 16) begin
            tests_failed++; $display("FAIL 4k_counts: timeout %b aw %0d w %0d expected 0 2 16", to, aw_addr_q.size(), w_data_q.size());
        end
        if (aw_addr_q.size() == 2) begin
            tests_run++;
            if (aw_addr_q[0] !== 32'h0FC0 || aw_len_q[0] !== 8'd3 || aw_addr_q[1] !== 32'h1000 || aw_len_q[1] !== 8'd11) begin
                tests_failed++; $display("FAIL 4k_aw: got %h/%0d %h/%0d expected fc0/3 1000/11",
                                         aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
            end
        end
        for (int i = 0; i < w_last_q.size(); i++) begin
            tests_run++;
            if (w_last_q[i] !== (i == 3 || i == 15) || w_data_q[i] !== mkword(i)) begin
                tests_failed++; $display("FAIL 4k_beat%0d: got last %b data %h expected last %b data %h",
                                         i, w_last_q[i], w_data_q[i], (i == 3 || i == 15), mkword(i));
            end
        end
    endtask

    task automatic test_stall();
        bit to; int b0; int r0; int s;
        clear_logs(); load_fifo(8);
        b0 = b_count; r0 = rd_cnt; viol = 0;
        stall_en = 1'b1;
        start_xfer(32'h3000, 16'd128);
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (w_data_q.size() >= 2) begin to = 1'b0; break; end
            @(negedge clock); #2;
        end
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL stall_first_beats: got timeout expected 2 beats"); end
        force_empty = 1'b1;
        s = w_data_q.size();
        repeat (5) begin @(negedge clock); #2; end
        tests_run++;
        if (w_data_q.size() !== s) begin
            tests_failed++; $display("FAIL stall_empty_hold: got %0d beats expected %0d", w_data_q.size(), s);
        end
        force_empty = 1'b0;
        wait_b(b0 + 1, to);
        stall_en = 1'b0;
        @(negedge clock); #2;
        tests_run++;
        if (to !== 1'b0 || w_data_q.size() !== 8 || rd_cnt - r0 !== 8) begin
            tests_failed++; $display("FAIL stall_counts: timeout %b w %0d rd %0d expected 0 8 8", to, w_data_q.size(), rd_cnt - r0);
        end
        tests_run++;
        if (viol !== 0) begin tests_failed++; $display("FAIL stall_protocol: got %0d violations expected 0", viol); end
        if (aw_len_q.size() > 0) begin
            tests_run++;
            if (aw_len_q[0] !== 8'd7) begin tests_failed++; $display("FAIL stall_awlen: got %0d expected 7", aw_len_q[0]); end
        end
        for (int i = 0; i < w_data_q.size(); i++) begin
            tests_run++;
            if (w_data_q[i] !== mkword(i)) begin
                tests_failed++; $display("FAIL stall_order%0d: got %h expected %h", i, w_data_q[i], mkword(i));
            end
        end
    endtask

    task automatic test_bresp();
        bit to; int b0;
        clear_logs(); load_fifo(19);
        b0 = b_count;
        slverr_idx = b0;
        start_xfer(32'h0, 16'd300);
        wait_b(b0 + 2, to);
        @(negedge clock); #2;
        slverr_idx = -1;
        tests_run++;
        if (to !== 1'b0 || o_err !== 1'b1) begin
            tests_failed++; $display("FAIL bresp_err: timeout %b err %b expected 0 1", to, o_err);
        end
        tests_run++;
        if (aw_addr_q.size() !== 2) begin
            tests_failed++; $display("FAIL bresp_continue: got %0d bursts expected 2", aw_addr_q.size());
        end else if (aw_addr_q[1] !== 32'h100) begin
            tests_failed++; $display("FAIL bresp_continue: got addr %h expected 100", aw_addr_q[1]);
        end
    endtask

    task automatic test_len_zero();
        clear_logs();
        start_xfer(32'h5000, 16'd0);
        tests_run++;
        if ({o_busy, o_awvalid, o_err} !== 3'b000) begin
            tests_failed++; $display("FAIL len0_status: busy,awvalid,err got %b expected 000", {o_busy, o_awvalid, o_err});
        end
        repeat (3) @(negedge clock);
        #2;
        tests_run++;
        if (aw_addr_q.size() !== 0) begin tests_failed++; $display("FAIL len0_traffic: got %0d bursts expected 0", aw_addr_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit to; int b0; int s;
        clear_logs(); load_fifo(19);
        start_xfer(32'h0, 16'd300);
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (w_data_q.size() >= 3) begin to = 1'b0; break; end
            @(negedge clock); #2;
        end
        reset_n = 1'b0;
        @(negedge clock); #2;
        tests_run++;
        if (to !== 1'b0 || {o_busy, o_awvalid, o_wvalid, o_wlast, o_bready, o_rd_en, o_err} !== 7'b0) begin
            tests_failed++; $display("FAIL midreset_outputs: timeout %b got %b expected 0000000", to,
                                     {o_busy, o_awvalid, o_wvalid, o_wlast, o_bready, o_rd_en, o_err});
        end
        s = fifo_q.size();
        repeat (3) @(negedge clock);
        #2;
        tests_run++;
        if (fifo_q.size() !== s) begin tests_failed++; $display("FAIL midreset_drain: got %0d words expected %0d", fifo_q.size(), s); end
        reset_n = 1'b1;
        fifo_q.delete(); clear_logs(); load_fifo(4);
        b0 = b_count;
        start_xfer(32'h1000, 16'd64);
        wait_b(b0 + 1, to);
        @(negedge clock); #2;
        tests_run++;
        if (to !== 1'b0 || o_busy !== 1'b0 || w_data_q.size() !== 4) begin
            tests_failed++; $display("FAIL midreset_restart: timeout %b busy %b beats %0d expected 0 0 4", to, o_busy, w_data_q.size());
        end
        if (aw_len_q.size() > 0) begin
            tests_run++;
            if (aw_addr_q[0] !== 32'h1000 || aw_len_q[0] !== 8'd3) begin
                tests_failed++; $display("FAIL midreset_aw: got %h/%0d expected 1000/3", aw_addr_q[0], aw_len_q[0]);
            end
        end
    endtask

    initial begin
        i_start = 1'b0;
        i_addr  = '0;
        i_len   = '0;
        test_reset();
        test_single();
        test_tail();
        test_multi();
        test_4k();
        test_stall();
        test_bresp();
        test_len_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_dma_burst_writer.md
# rx_dma_burst_writer

Drains the RX data FIFO of the SP RX unit into system memory over AXI4 write bursts. Sits directly downstream of the RX data FIFO in the processor clock domain. A single `start` pulse on the memory-write command interface latches a destination address and byte length; the block issues INCR bursts, never crosses 4 KiB, masks the tail beat with WSTRB and reports `busy` until the last write response returns.

## Interface
- `AXI_ADDR_WIDTH`, 32, address width of `mem_w.addr` and AWADDR
- `DATA_WIDTH`, 128, FIFO word and WDATA width; power of two, 32..512
- `MAX_BURST_BEATS`, 16, upper bound on beats per burst; power of two, 1..256
- `clock`  in  1  sole clock (processor clock domain)
- `reset_n`  in  1  synchronous, active-low reset
- `mem_w`  memory_write_interface (slave)  `start` in (1-cycle pulse), `addr` in AXI_ADDR_WIDTH, `len` in 16 (bytes), `busy` out 1
- `fifo_r`  fifo_read_interface (master, FWFT)  `rd_en` out, `rd_data` in DATA_WIDTH, `empty` in
- `axi_aw`  axi_write_address_channel (master)  AWADDR, AWLEN[7:0], AWSIZE, AWBURST, AWVALID/AWREADY
- `axi_w`  axi_write_channel (master)  WDATA, WSTRB[DATA_WIDTH/8], WLAST, WVALID/WREADY
- `axi_b`  axi_write_response_channel (master)  BRESP[1:0], BVALID/BREADY
- `err`  out  1  sticky; set on any BRESP != OKAY, cleared by accepted `start`

## Operation
- BYTES = DATA_WIDTH/8. `start` accepted only in IDLE; ignored while busy.
- On accept: addr latched with low log2(BYTES) bits forced 0; beats_left = ceil(len/BYTES); tail = len mod BYTES. `len`=0: no AXI traffic, busy stays 0, err cleared.
- States: IDLE -> AW (accept, len≠0) -> W (AW handshake) -> B (W handshake with WLAST) -> AW (BVALID, beats_left≠0) or IDLE (BVALID, beats_left=0).
- Burst size n = min(beats_left, MAX_BURST_BEATS, (4096 - addr[11:0])/BYTES); AWLEN = n-1; AWSIZE = log2(BYTES); AWBURST = INCR.
- W: WVALID = !empty in W; WDATA = rd_data; rd_en = WVALID & WREADY. WLAST on beat n of burst.
- WSTRB all ones except final beat of whole transfer with tail≠0: low `tail` bits set.
- After AW handshake: addr += n*BYTES, beats_left -= n. One burst outstanding max.
- BREADY = 1 in B only. Non-OKAY BRESP sets `err`; transfer continues to completion.

## Timing
- Reset values: busy 0, err 0, AWVALID 0, WVALID 0, WLAST 0, BREADY 0, rd_en 0, state IDLE.
- `start` at cycle 0 -> busy=1 and AWVALID=1 at cycle 1 (registered).
- AWVALID/AWADDR/AWLEN stable until AWREADY; W phase begins cycle after AW handshake.
- FIFO empty mid-burst: WVALID low, no rd_en, beat counter frozen; resumes on !empty.
- Final BVALID&BREADY at cycle k -> busy=0 at k+1; new `start` accepted at k+1.
- Reset asserted mid-transfer: next edge all outputs to reset values; FIFO contents not drained; partial burst abandoned.
- Counters: beats_left 13 bits (ceil(65535/16)), beat counter 9 bits; no wrap.

## Structure
- Shared package `rx_dma_pkg`: state enum (IDLE, AW, W, B), AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00.
- One combinational sub-module `axi_burst_len_calc` (beats_left, addr, MAX_BURST_BEATS, BYTES -> n); FSM, counters, strobe logic in top.

## Test plan
- addr 0x1000, len 64, DATA_WIDTH 128 -> one burst AWADDR 0x1000 AWLEN 3, 4 beats WSTRB 0xFFFF, WLAST on 4th, busy drops cycle after BVALID.
- addr 0x2000, len 60 -> AWLEN 3, last beat WSTRB 0x0FFF, exactly 4 rd_en pulses.
- addr 0x0, len 300 -> bursts AWLEN 15 @0x000, AWLEN 2 @0x100; last WSTRB 0x0FFF; 19 rd_en.
- addr 0x0FC0, len 256 -> AWLEN 3 @0x0FC0 then AWLEN 11 @0x1000; no burst crosses 4 KiB.
- FIFO empty 5 cycles mid-burst plus random WREADY/AWREADY stalls -> WVALID low while empty, data order preserved, no dropped/duplicated words.
- BRESP SLVERR on burst 1 of 300-byte transfer -> err=1, burst 2 still issued; reset_n low during W -> busy/valids 0 next cycle, next start works.
